// File: rtl/fp_accumulate.sv
// Streaming FP vector reducer: elements alternate between two partial-sum lanes
// feeding one 2-cycle fp_add, then the two lanes are combined into the vector sum.

module fp_add #(
  parameter int EXP   = 8,
  parameter int MANT  = 7,
  parameter int WIDTH = EXP + MANT + 1
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] result
);
  // carry | hidden 1 | MANT | 3 guard bits; lower bits are truncated, denormals flush to zero
  localparam int SW  = MANT + 5;
  localparam int LZW = $clog2(SW);

  function automatic logic [LZW-1:0] clz(input logic [SW-2:0] v);
    clz = LZW'(SW - 1);
    for (int i = 0; i < SW - 1; i++)
      if (v[i]) clz = LZW'(SW - 2 - i);
  endfunction

  logic             w_swap, w_sub;
  logic [WIDTH-1:0] w_big, w_sml;
  logic [EXP-1:0]   w_eb, w_es;
  logic [SW-1:0]    w_big_x, w_sml_x, w_sum;

  logic             r_s1_sign;
  logic [EXP-1:0]   r_s1_exp;
  logic [SW-1:0]    r_s1_sum;

  always_comb begin
    w_swap  = datab[WIDTH-2:0] > dataa[WIDTH-2:0];
    w_big   = w_swap ? datab : dataa;
    w_sml   = w_swap ? dataa : datab;
    w_eb    = w_big[WIDTH-2 -: EXP];
    w_es    = w_sml[WIDTH-2 -: EXP];
    w_big_x = (w_eb != '0) ? {2'b01, w_big[MANT-1:0], 3'b000} : '0;
    w_sml_x = (w_es != '0) ? ({2'b01, w_sml[MANT-1:0], 3'b000} >> (w_eb - w_es)) : '0;
    w_sub   = w_big[WIDTH-1] ^ w_sml[WIDTH-1];
    w_sum   = w_sub ? (w_big_x - w_sml_x) : (w_big_x + w_sml_x);
  end

  always_ff @(posedge clock) begin
    r_s1_sign <= w_big[WIDTH-1];
    r_s1_exp  <= w_eb;
    r_s1_sum  <= w_sum;
  end

  logic [LZW-1:0]  w_lz;
  logic [EXP-1:0]  w_lz_e, w_exp_inc;
  logic [SW-1:0]   w_norm;
  logic [MANT-1:0] w_mant;
  logic [WIDTH-1:0] w_res;

  always_comb begin
    w_lz      = clz(r_s1_sum[SW-2:0]);
    w_lz_e    = {{(EXP-LZW){1'b0}}, w_lz};
    w_exp_inc = r_s1_exp + 1'b1;
    w_norm    = r_s1_sum[SW-1] ? (r_s1_sum >> 1) : (r_s1_sum << w_lz);
    w_mant    = MANT'(w_norm >> (SW - 2 - MANT));
    if (r_s1_sum == '0)
      w_res = '0;
    else if (r_s1_sum[SW-1])
      w_res = (&w_exp_inc) ? {r_s1_sign, {EXP{1'b1}}, {MANT{1'b0}}}
                           : {r_s1_sign, w_exp_inc, w_mant};
    else if (w_lz_e >= r_s1_exp)
      w_res = '0;
    else
      w_res = {r_s1_sign, r_s1_exp - w_lz_e, w_mant};
  end

  always_ff @(posedge clock)
    result <= w_res;
endmodule

module fp_accumulate #(
  parameter int EXP   = 8,
  parameter int MANT  = 7,
  parameter int WIDTH = EXP + MANT + 1
) (
  input  logic             clock,
  input  logic             clock_sreset,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  typedef enum logic [1:0] {ACCUM, DRAIN, FINAL} state_t;
  typedef struct packed { logic v; logic lane; logic fin; } tag_t;

  state_t                  r_state;
  logic                    r_lane;
  logic [1:0]              r_used;
  logic [1:0][WIDTH-1:0]   r_acc;
  tag_t [2:1]              r_tag;
  logic [WIDTH-1:0]        r_out;

  logic                    w_accept, w_ret, w_out, w_fin_issue;
  logic [1:0][WIDTH-1:0]   w_part;
  logic [WIDTH-1:0]        w_dataa, w_datab, w_res;
  tag_t                    w_tag0;

  assign in_ready  = (r_state == ACCUM) & ~clock_sreset;
  assign w_accept  = in_valid & in_ready;
  assign w_ret     = r_tag[2].v & ~r_tag[2].fin;
  assign w_out     = r_tag[2].v & r_tag[2].fin;
  assign out_valid = w_out & ~clock_sreset;
  assign out_data  = clock_sreset ? '0 : (w_out ? w_res : r_out);

  // A lane result returning this cycle bypasses the not-yet-written accumulator
  for (genvar l = 0; l < 2; l++) begin : g_part
    assign w_part[l] = (w_ret && r_tag[2].lane == 1'(l)) ? w_res : r_acc[l];
  end

  // DRAIN is exactly one cycle, so the first lane return seen in FINAL is the last element's
  assign w_fin_issue = (r_state == FINAL) & w_ret;

  always_comb begin
    w_dataa = in_data;
    w_datab = r_used[r_lane] ? w_part[r_lane] : '0;
    if (w_fin_issue) begin
      w_dataa = r_used[0] ? w_part[0] : '0;
      w_datab = r_used[1] ? w_part[1] : '0;
    end
    w_tag0 = '{v: w_accept | w_fin_issue, lane: r_lane, fin: w_fin_issue};
  end

  fp_add #(.EXP(EXP), .MANT(MANT), .WIDTH(WIDTH)) u_add (
    .clock  (clock),
    .dataa  (w_dataa),
    .datab  (w_datab),
    .result (w_res)
  );

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_state <= ACCUM;
      r_lane  <= 1'b0;
      r_used  <= '0;
      r_acc   <= '0;
      r_tag   <= '0;
      r_out   <= '0;
    end else begin
      r_tag <= {r_tag[1], w_tag0};
      if (w_ret) r_acc[r_tag[2].lane] <= w_res;
      if (w_out) r_out <= w_res;
      case (r_state)
        ACCUM: if (w_accept) begin
          r_used[r_lane] <= 1'b1;
          r_lane         <= in_last ? 1'b0 : ~r_lane;
          if (in_last) r_state <= DRAIN;
        end
        DRAIN: r_state <= FINAL;
        FINAL: if (w_out) begin
          r_state <= ACCUM;
          r_used  <= '0;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end
endmodule

// File: doc/fp_accumulate.md
# fp_accumulate

Streaming floating-point vector reducer. Consumes a stream of [s|e|m] operands framed by a last flag and returns their sum. It drives an internal `fp_add` instance, which has a 2-cycle latency, as its only arithmetic unit. Successive elements are interleaved across two partial-sum lanes so the adder can accept one element per cycle without read-after-write stalls. It sits between the MAC product stream and the activation/writeback stage.

## Interface
- `EXP`, 8, exponent width
- `MANT`, 7, stored mantissa width (implied leading 1)
- `WIDTH`, `EXP+MANT+1`, word width
- `clock`  in  1  sole clock; all state updates on rising edge
- `clock_sreset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in_data` valid this cycle
- `in_last`  in  1  qualifies the final element of a vector
- `in_data`  in  WIDTH  operand
- `in_ready`  out  1  block accepts an element this cycle; an element transfers when `in_valid & in_ready`
- `out_valid`  out  1  single-cycle pulse, `out_data` holds the vector sum
- `out_data`  out  WIDTH  vector sum, held until the next `out_valid`

## Operation
- States: ACCUM, DRAIN, FINAL.
  - ACCUM: `in_ready` = 1.
  - Accepting an element with `in_last` moves to DRAIN.
  - DRAIN lasts 1 cycle and moves to FINAL.
  - FINAL issues the lane combine and waits for its result.
  - When the final result returns, the block pulses `out_valid` and returns to ACCUM.
- Lanes: element index k (counted from 0 within the vector) uses lane k[0]. The lane bit toggles on each accepted element and is cleared at vector start.
- Issue for an accepted element:
  - `dataa` = `in_data`.
  - `datab` = the lane's partial sum, or +0 (all-zero word) if this is the lane's first element in the vector.
- Partial-sum source:
  - If the adder output is valid this cycle and its tag lane matches, forward the adder `result`.
  - Otherwise use the lane register `acc[lane]`.
- Tag pipeline: {valid, lane, final} travels alongside the adder for 2 stages.
  - Every valid non-final adder output is written to `acc[tag lane]`.
  - The same lane is reissued no sooner than 2 cycles later, so forwarding always suffices and no stall is needed in ACCUM.
- Final combine, issued in the cycle the last element's result emerges:
  - `dataa` = lane 0 partial, `datab` = lane 1 partial, with the returning value forwarded.
  - Lane 1 is +0 for a 1-element vector.
- Arithmetic, rounding, truncation and zero handling are exactly those of `fp_add`; the summation order defined above is normative.
- Bubbles (`in_valid` = 0) in ACCUM are allowed at any point. Lane state is unaffected.

## Timing
- Last element accepted in cycle t:
  - `in_ready` = 0 in cycles t+1..t+4 and returns to 1 in cycle t+5.
  - Last element's sum emerges at t+2; the final combine is issued at t+2.
  - `out_valid` = 1 in cycle t+4 only, with `out_data` valid the same cycle.
- Minimum vector-to-vector gap: 4 cycles.
- Throughput: one element per cycle within a vector.
- Reset (synchronous, any state, including mid-vector):
  - State becomes ACCUM; lanes and first-flags are cleared; the tag pipeline is invalidated.
  - `out_valid` = 0 and `out_data` = 0.
  - `in_ready` = 0 while `clock_sreset` is high and 1 in the first cycle after.
  - In-flight adder results are discarded, with no stale `out_valid`.
- `in_last` is ignored unless `in_valid & in_ready`. `in_valid` while `in_ready` = 0 is not accepted and must be held by the source.

## Test plan
- Continuous vector 1.0, 2.0, 3.0, 4.0 (0x3F80, 0x4000, 0x4040, 0x4080; last on 4.0), accepted t..t+3 -> `out_valid` only at t+7, `out_data` = 0x4120 (10.0); `in_ready` low t+4..t+7.
- Same vector with 1-3 idle cycles between elements -> `out_data` = 0x4120, `out_valid` 4 cycles after the last accept.
- Single element 0x4040 with last -> `out_data` = 0x4040 at t+4.
- Cancellation: 0x40A0 (5.0), 0xC0A0 (-5.0, last) -> `out_data` = 0x0000.
- Back-to-back vectors {1.0, 2.0} then {4.0}, each presented as soon as `in_ready` allows -> 0x4040 then 0x4080; no element dropped or merged.
- Reset mid-vector after 2 elements and a pending adder result, then vector {0x3F80 last} -> exactly one `out_valid` with 0x3F80; no output during or due to the aborted vector.
